// File: rtl/cellrv32_npu_pkg.sv
// Shared NPU package: instruction format, address/length widths, the
// matrix-multiply opcode bit positions and the per-row pipeline payloads
// carried by the matrix-multiply control delay lines.
package cellrv32_npu_pkg;

  localparam int BUFFER_ADDRESS_WIDTH      = 24;
  localparam int ACCUMULATOR_ADDRESS_WIDTH = 16;
  localparam int LENGTH_WIDTH              = 32;
  localparam int OPCODE_WIDTH              = 8;

  // Matrix-multiply opcode bit positions.
  localparam int MATRIX_MULTIPLY_ACCUMULATE_BIT = 0;
  localparam int MATRIX_MULTIPLY_WEIGHTS_BIT    = 1;
  localparam int MATRIX_MULTIPLY_SIGNED_BIT     = 2;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]              opcode;
    logic [LENGTH_WIDTH-1:0]              calc_len;
    logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_addr;
    logic [BUFFER_ADDRESS_WIDTH-1:0]      buff_addr;
  } instruction_t;

  typedef enum logic {
    MMUL_IDLE,
    MMUL_RUN
  } mmul_state_t;

  // Row payload between the buffer read and the MMU input.
  typedef struct packed {
    logic                                 activate;
    logic                                 signed_mul;
    logic                                 accumulate;
    logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_addr;
  } mmu_row_t;

  // Row payload between the MMU input and the accumulator write port.
  typedef struct packed {
    logic                                 accumulate;
    logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_addr;
  } acc_row_t;

endpackage

// File: rtl/cellrv32_npu_counter.sv
// Down counter for instruction lengths.
// Ports: clk_i, rstn_i (async, active-low), enable (global stall),
//        load/load_value (start a new length), count_en (one row issued),
//        last (current row is the final one; a length of 0 counts as 1).
module cellrv32_npu_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  output logic             last
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count <= '0;
    end else if (enable) begin
      if (load) begin
        count <= load_value;
      end else if (count_en && (count != '0)) begin
        count <= count - 1'b1;
      end
    end
  end

  assign last = (count[WIDTH-1:1] == '0);

endmodule

// File: rtl/cellrv32_npu_delay_line.sv
// Fixed-depth shift register carrying a valid bit plus a payload.
// Ports: clk_i, rstn_i (async clear, active-low), enable (global stall),
//        valid_in/data_in, valid_out/data_out (DEPTH enabled cycles later),
//        active (any stage holds a valid row).
module cellrv32_npu_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             enable,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             active
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // NOTE: the payload stages are reset too, not just the valid bits, because
  // the address outputs driven from this line must read 0 out of reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else if (enable) begin
      valid_q[0] <= valid_in;
      data_q[0]  <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_out = valid_q[DEPTH-1];
  assign data_out  = data_q[DEPTH-1];
  assign active    = |valid_q;

endmodule

// File: rtl/cellrv32_npu_load_counter.sv
// Loadable up counter used for buffer and accumulator addresses.
// Ports: clk_i, rstn_i (async, active-low), enable (global stall),
//        load/start_value, count_en (increment), value. Wraps modulo 2^WIDTH.
module cellrv32_npu_load_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] start_value,
  input  logic             count_en,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      value <= '0;
    end else if (enable) begin
      if (load) begin
        value <= start_value;
      end else if (count_en) begin
        value <= value + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cellrv32_npu_matrix_multiply_control.sv
// Matrix-multiply control: accepts an instruction, issues one unified-buffer
// read per row, and delays per-row strobes so MMU input valid lands one cycle
// after the read and the accumulator write lands MATRIX_WIDTH+2 cycles later.
// Ports: clk_i, rstn_i (async, active-low), enable_i (global stall),
//        inst_i/inst_en_i (instruction in), buff_addr_o/buff_rd_en_o (reads),
//        mmu_sds_en_o/mmu_signed_o/activate_weight_o (MMU side),
//        acc_addr_o/accumulate_o/acc_wr_en_o (accumulator side),
//        busy_o (issuing), resource_busy_o (issuing or rows in flight).
module cellrv32_npu_matrix_multiply_control
  import cellrv32_npu_pkg::*;
#(
  parameter int MATRIX_WIDTH = 14
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 enable_i,
  input  instruction_t                         inst_i,
  input  logic                                 inst_en_i,
  output logic [BUFFER_ADDRESS_WIDTH-1:0]      buff_addr_o,
  output logic                                 buff_rd_en_o,
  output logic                                 mmu_sds_en_o,
  output logic                                 mmu_signed_o,
  output logic                                 activate_weight_o,
  output logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_addr_o,
  output logic                                 accumulate_o,
  output logic                                 acc_wr_en_o,
  output logic                                 busy_o,
  output logic                                 resource_busy_o
);

  localparam int ACC_DELAY = MATRIX_WIDTH + 2;

  mmul_state_t state, state_next;
  logic        accept, last_row;
  logic        op_accumulate, op_weights, op_signed, first_row;
  logic [BUFFER_ADDRESS_WIDTH-1:0]      buff_cnt, buff_addr_hold;
  logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_cnt, acc_addr_hold;
  mmu_row_t    mmu_row_in, mmu_row_out;
  acc_row_t    acc_row_in, acc_row_out;
  logic        mmu_valid, acc_valid, mmu_active, acc_active;
  logic        unused_opcode_bits;

  // Only the three matrix-multiply bits matter to this unit.
  assign unused_opcode_bits = ^inst_i.opcode[OPCODE_WIDTH-1:3];

  assign accept = enable_i && inst_en_i && (state == MMUL_IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= MMUL_IDLE;
    else if (enable_i) state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch
    // is inferred.
    state_next   = state;
    busy_o       = 1'b0;
    buff_rd_en_o = 1'b0;
    case (state)
      MMUL_IDLE: if (inst_en_i) state_next = MMUL_RUN;
      MMUL_RUN: begin
        busy_o       = 1'b1;
        buff_rd_en_o = 1'b1;
        if (last_row) state_next = MMUL_IDLE;
      end
      default: state_next = MMUL_IDLE;
    endcase
  end

  // Opcode bits live for the instruction; each row copies them into the
  // pipeline, so overlapping rows of consecutive instructions stay distinct.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      op_accumulate  <= 1'b0;
      op_weights     <= 1'b0;
      op_signed      <= 1'b0;
      first_row      <= 1'b0;
      buff_addr_hold <= '0;
      acc_addr_hold  <= '0;
    end else if (enable_i) begin
      if (accept) begin
        op_accumulate <= inst_i.opcode[MATRIX_MULTIPLY_ACCUMULATE_BIT];
        op_weights    <= inst_i.opcode[MATRIX_MULTIPLY_WEIGHTS_BIT];
        op_signed     <= inst_i.opcode[MATRIX_MULTIPLY_SIGNED_BIT];
        first_row     <= 1'b1;
      end else if (busy_o) begin
        first_row <= 1'b0;
      end
      if (busy_o)    buff_addr_hold <= buff_cnt;
      if (acc_valid) acc_addr_hold  <= acc_row_out.acc_addr;
    end
  end

  cellrv32_npu_counter #(.WIDTH(LENGTH_WIDTH)) u_length (
    .clk_i, .rstn_i, .enable(enable_i), .load(accept),
    .load_value(inst_i.calc_len), .count_en(busy_o), .last(last_row)
  );

  cellrv32_npu_load_counter #(.WIDTH(BUFFER_ADDRESS_WIDTH)) u_buff_addr (
    .clk_i, .rstn_i, .enable(enable_i), .load(accept),
    .start_value(inst_i.buff_addr), .count_en(busy_o), .value(buff_cnt)
  );

  cellrv32_npu_load_counter #(.WIDTH(ACCUMULATOR_ADDRESS_WIDTH)) u_acc_addr (
    .clk_i, .rstn_i, .enable(enable_i), .load(accept),
    .start_value(inst_i.acc_addr), .count_en(busy_o), .value(acc_cnt)
  );

  // Strobe-like payload bits are gated with the row valid so they read 0
  // outside rows; the address is carried as-is and held at the output.
  always_comb begin
    mmu_row_in.activate   = busy_o && op_weights && first_row;
    mmu_row_in.signed_mul = busy_o && op_signed;
    mmu_row_in.accumulate = busy_o && op_accumulate;
    mmu_row_in.acc_addr   = acc_cnt;
  end

  cellrv32_npu_delay_line #(.WIDTH($bits(mmu_row_t)), .DEPTH(1)) u_mmu_stage (
    .clk_i, .rstn_i, .enable(enable_i),
    .valid_in(busy_o), .data_in(mmu_row_in),
    .valid_out(mmu_valid), .data_out(mmu_row_out), .active(mmu_active)
  );

  assign acc_row_in = '{accumulate: mmu_row_out.accumulate, acc_addr: mmu_row_out.acc_addr};

  cellrv32_npu_delay_line #(.WIDTH($bits(acc_row_t)), .DEPTH(ACC_DELAY)) u_acc_stage (
    .clk_i, .rstn_i, .enable(enable_i),
    .valid_in(mmu_valid), .data_in(acc_row_in),
    .valid_out(acc_valid), .data_out(acc_row_out), .active(acc_active)
  );

  assign buff_addr_o       = busy_o ? buff_cnt : buff_addr_hold;
  assign mmu_sds_en_o      = mmu_valid;
  assign mmu_signed_o      = mmu_row_out.signed_mul;
  assign activate_weight_o = mmu_row_out.activate;
  assign acc_wr_en_o       = acc_valid;
  assign accumulate_o      = acc_row_out.accumulate;
  assign acc_addr_o        = acc_valid ? acc_row_out.acc_addr : acc_addr_hold;
  assign resource_busy_o   = busy_o || mmu_active || acc_active;

endmodule

// File: tb/tb_cellrv32_npu_matrix_multiply_control.sv
// Directed bench for the matrix-multiply control (MATRIX_WIDTH=14). Cycle 0
// is the cycle in which an instruction is presented; outputs are sampled 1
// time unit after each rising edge.
module tb_cellrv32_npu_matrix_multiply_control;
  import cellrv32_npu_pkg::*;

  logic clk = 1'b0;
  logic rstn, enable, inst_en;
  instruction_t inst;
  logic [BUFFER_ADDRESS_WIDTH-1:0]      buff_addr;
  logic [ACCUMULATOR_ADDRESS_WIDTH-1:0] acc_addr;
  logic rd_en, mmu_en, mmu_signed, act_w, accumulate, acc_wr, busy, rbusy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  cellrv32_npu_matrix_multiply_control #(.MATRIX_WIDTH(14)) dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable),
    .inst_i(inst), .inst_en_i(inst_en),
    .buff_addr_o(buff_addr), .buff_rd_en_o(rd_en),
    .mmu_sds_en_o(mmu_en), .mmu_signed_o(mmu_signed),
    .activate_weight_o(act_w), .acc_addr_o(acc_addr),
    .accumulate_o(accumulate), .acc_wr_en_o(acc_wr),
    .busy_o(busy), .resource_busy_o(rbusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [2:0] op, input int len,
                       input logic [23:0] ba, input logic [15:0] aa);
    inst.opcode    = {5'b0, op};
    inst.calc_len  = len;
    inst.buff_addr = ba;
    inst.acc_addr  = aa;
    inst_en        = 1'b1;
    cyc            = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy),       0);
    check({tag, "_rd"},    32'(rd_en),      0);
    check({tag, "_mmu"},   32'(mmu_en),     0);
    check({tag, "_sgn"},   32'(mmu_signed), 0);
    check({tag, "_act"},   32'(act_w),      0);
    check({tag, "_wr"},    32'(acc_wr),     0);
    check({tag, "_accum"}, 32'(accumulate), 0);
    check({tag, "_rbusy"}, 32'(rbusy),      0);
    check({tag, "_baddr"}, 32'(buff_addr),  0);
    check({tag, "_aaddr"}, 32'(acc_addr),   0);
  endtask

  initial begin
    int nbusy, nwr;
    rstn = 1'b0; enable = 1'b1; inst_en = 1'b0; inst = '0;
    tick();
    check_all_zero("reset");
    tick();
    rstn = 1'b1;
    tick(); tick();

    // Single row.
    issue(3'b000, 1, 24'h10, 16'h4);
    for (int c = 1; c <= 20; c++) begin
      tick(); inst_en = 1'b0;
      check("s1_busy", 32'(busy),   32'(c == 1));
      check("s1_rd",   32'(rd_en),  32'(c == 1));
      if (c == 1) check("s1_raddr", 32'(buff_addr), 32'h10);
      check("s1_mmu",  32'(mmu_en), 32'(c == 2));
      check("s1_wr",   32'(acc_wr), 32'(c == 18));
      if (c == 18) begin
        check("s1_waddr", 32'(acc_addr), 32'h4);
        check("s1_accum", 32'(accumulate), 0);
      end
      check("s1_rbusy", 32'(rbusy), 32'(c <= 18));
    end

    // Burst with accumulate, signed and weights.
    issue(3'b111, 4, 24'h20, 16'h8);
    for (int c = 1; c <= 22; c++) begin
      tick(); inst_en = 1'b0;
      check("s2_rd", 32'(rd_en), 32'(c >= 1 && c <= 4));
      if (c <= 4) check("s2_raddr", 32'(buff_addr), 32'(32'h20 + c - 1));
      check("s2_mmu", 32'(mmu_en),     32'(c >= 2 && c <= 5));
      check("s2_sgn", 32'(mmu_signed), 32'(c >= 2 && c <= 5));
      check("s2_act", 32'(act_w),      32'(c == 2));
      check("s2_wr",  32'(acc_wr),     32'(c >= 18 && c <= 21));
      check("s2_accum", 32'(accumulate), 32'(c >= 18 && c <= 21));
      if (c >= 18 && c <= 21) check("s2_waddr", 32'(acc_addr), 32'(32'h8 + c - 18));
      if (c == 22) check("s2_hold_waddr", 32'(acc_addr), 32'hB);
    end

    // Back-to-back: second instruction held on inst_en from cycle 1.
    issue(3'b001, 2, 24'h40, 16'h10);
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 1) begin
        inst.opcode = '0; inst.calc_len = 2; inst.buff_addr = 24'h50; inst.acc_addr = 16'h30;
      end
      if (c == 4) inst_en = 1'b0;
      check("s3_busy", 32'(busy),  32'(c inside {1, 2, 4, 5}));
      check("s3_rd",   32'(rd_en), 32'(c inside {1, 2, 4, 5}));
      if (c inside {1, 2}) check("s3_raddr_a", 32'(buff_addr), 32'(32'h40 + c - 1));
      if (c inside {4, 5}) check("s3_raddr_b", 32'(buff_addr), 32'(32'h50 + c - 4));
      check("s3_wr",    32'(acc_wr),     32'(c inside {18, 19, 21, 22}));
      check("s3_accum", 32'(accumulate), 32'(c inside {18, 19}));
      if (c inside {18, 19}) check("s3_waddr_a", 32'(acc_addr), 32'(32'h10 + c - 18));
      if (c inside {21, 22}) check("s3_waddr_b", 32'(acc_addr), 32'(32'h30 + c - 21));
    end

    // Stall in cycles 2..4.
    issue(3'b000, 3, 24'h60, 16'h20);
    for (int c = 1; c <= 25; c++) begin
      tick(); inst_en = 1'b0;
      if (c == 2) enable = 1'b0;
      if (c == 5) enable = 1'b1;
      check("s4_busy", 32'(busy),  32'(c >= 1 && c <= 6));
      check("s4_rd",   32'(rd_en), 32'(c >= 1 && c <= 6));
      if (c == 1) check("s4_raddr0", 32'(buff_addr), 32'h60);
      if (c >= 2 && c <= 5) check("s4_raddr1", 32'(buff_addr), 32'h61);
      if (c == 6) check("s4_raddr2", 32'(buff_addr), 32'h62);
      check("s4_mmu", 32'(mmu_en), 32'(c >= 2 && c <= 7));
      check("s4_wr",  32'(acc_wr), 32'(c >= 21 && c <= 23));
      if (c >= 21 && c <= 23) check("s4_waddr", 32'(acc_addr), 32'(32'h20 + c - 21));
      check("s4_rbusy", 32'(rbusy), 32'(c <= 23));
    end

    // inst_en while stalled is not accepted.
    issue(3'b000, 2, 24'h1, 16'h1);
    enable = 1'b0;
    tick(); tick();
    inst_en = 1'b0; enable = 1'b1;
    tick();
    check("stall_accept_busy", 32'(busy),  0);
    check("stall_accept_rd",   32'(rd_en), 0);

    // Address wrap.
    issue(3'b000, 2, 24'hFFFFFF, 16'hFFFF);
    for (int c = 1; c <= 20; c++) begin
      tick(); inst_en = 1'b0;
      check("s5_rd", 32'(rd_en), 32'(c <= 2));
      if (c == 1) check("s5_raddr_max", 32'(buff_addr), 32'hFFFFFF);
      if (c == 2) check("s5_raddr_wrap", 32'(buff_addr), 32'h0);
      check("s5_wr", 32'(acc_wr), 32'(c inside {18, 19}));
      if (c == 18) check("s5_waddr_max", 32'(acc_addr), 32'hFFFF);
      if (c == 19) check("s5_waddr_wrap", 32'(acc_addr), 32'h0);
    end

    // calc_len = 0 behaves as one row.
    issue(3'b000, 0, 24'h5, 16'h7);
    nbusy = 0; nwr = 0;
    for (int c = 1; c <= 20; c++) begin
      tick(); inst_en = 1'b0;
      if (busy) nbusy++;
      if (acc_wr) nwr++;
      if (c == 1) check("s6_raddr", 32'(buff_addr), 32'h5);
      if (c == 18) check("s6_waddr", 32'(acc_addr), 32'h7);
    end
    check("s6_busy_cycles", 32'(nbusy), 1);
    check("s6_writes", 32'(nwr), 1);

    // Reset in the middle of an 8-row run.
    issue(3'b111, 8, 24'h0, 16'h40);
    for (int c = 1; c <= 5; c++) begin
      tick(); inst_en = 1'b0;
      check("s7_rd", 32'(rd_en), 1);
    end
    tick();
    rstn = 1'b0;
    #1;
    check_all_zero("s7_rst");
    tick(); tick();
    rstn = 1'b1;
    for (int c = 9; c <= 30; c++) begin
      tick();
      check("s7_no_wr", 32'(acc_wr), 0);
      check("s7_rbusy", 32'(rbusy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cellrv32_npu_matrix_multiply_control.md
# cellrv32_npu_matrix_multiply_control

Control unit for the matrix-multiply instruction. It streams rows from the unified buffer into the systolic data setup and MMU, then drives the accumulator write port. It is the producer of accumulator contents that the activation control later drains. Accumulator-side strobes are delayed to match MMU latency, so rows land in the accumulators exactly when the MMU emits them.

## Interface
Parameters:
- MATRIX_WIDTH, 14, systolic array dimension; sets the MMU delay.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  global stall; 0 freezes every register, including counters
- inst_i  in  instruction_t  matrix-multiply instruction; fields opcode, calc_len, buff_addr, acc_addr
- inst_en_i  in  1  instruction valid; accepted only when busy_o=0
- buff_addr_o  out  BUFFER_ADDRESS_WIDTH  unified buffer read address
- buff_rd_en_o  out  1  unified buffer read enable
- mmu_sds_en_o  out  1  systolic data setup / MMU input valid
- mmu_signed_o  out  1  signed (1) / unsigned (0) multiply
- activate_weight_o  out  1  one-cycle weight-switch pulse on the first row
- acc_addr_o  out  ACCUMULATOR_ADDRESS_WIDTH  accumulator write address
- accumulate_o  out  1  1 = add to stored value; 0 = overwrite
- acc_wr_en_o  out  1  accumulator write enable
- busy_o  out  1  issuing reads; do not feed a new instruction
- resource_busy_o  out  1  issue is active or rows are still in flight to the accumulators

## Operation
- Opcode bits:
  - opcode[0] = accumulate
  - opcode[1] = activate weights
  - opcode[2] = signed
  - These bits are latched at acceptance and held until the instruction retires.
- States:
  - IDLE: busy_o=0.
  - RUN: busy_o=1.
- Transitions:
  - IDLE -> RUN when inst_en_i=1.
    - Load buffer address counter with buff_addr.
    - Load accumulator address counter with acc_addr.
    - Load length counter with calc_len.
  - RUN -> IDLE on the length counter event (last row issued).
  - inst_en_i is ignored while in RUN.
- Row count N = calc_len. calc_len=0 is treated as N=1.
- In RUN, each enabled cycle:
  - Issue one read: buff_rd_en_o=1 at the current buffer address.
  - Both address counters then increment by 1.
- Both address counters wrap modulo 2^width with no error flag.
- Pipeline alignment for each issued row:
  - mmu_sds_en_o and mmu_signed_o follow buff_rd_en_o by 1 cycle (buffer read latency).
  - activate_weight_o is asserted only alongside the first row's mmu_sds_en_o, and only if opcode[1]=1.
  - acc_wr_en_o, acc_addr_o and accumulate_o follow mmu_sds_en_o by ACC_DELAY = MATRIX_WIDTH+2 cycles.
- Outside valid rows, strobes are 0 and address outputs hold their last pipeline value.
- resource_busy_o = busy_o OR any valid bit in the delay pipelines.

## Timing
- Reset value of every output is 0. Asynchronous reset clears state, counters, latched opcode bits and all delay pipelines. In-flight accumulator writes are dropped and never emitted.
- For acceptance at cycle 0, row k (0-based) produces:
  - read at cycle 1+k
  - MMU valid at 2+k
  - accumulator write at 2+k+ACC_DELAY (cycle 18+k for MATRIX_WIDTH=14)
- busy_o is high in cycles 1..N.
- Back-to-back instructions:
  - The next instruction can be accepted in cycle N+1, when busy_o=0.
  - Its first read is at cycle N+2, giving exactly one bubble.
  - Pipelines are per-row, so overlapping in-flight rows of two instructions keep their own opcode bits.
- enable_i=0 freezes all state, outputs hold. Latencies are counted in enabled cycles only.
- inst_en_i together with enable_i=0 is not accepted.

## Structure
- Shared NPU package holds instruction_t, BUFFER_ADDRESS_WIDTH, ACCUMULATOR_ADDRESS_WIDTH and LENGTH_WIDTH. Add the MATRIX_MULTIPLY opcode bit-position constants there.
- Existing sub-modules are reused:
  - cellrv32_npu_counter for length
  - two cellrv32_npu_load_counter instances for the addresses
- One new sub-module: cellrv32_npu_delay_line #(WIDTH, DEPTH), with enable and asynchronous clear. It is used for the 1-cycle MMU stage and for the ACC_DELAY accumulator stage. It carries {valid, accumulate, acc_addr}.

## Test plan
All scenarios use MATRIX_WIDTH=14.
- Single row: opcode=0, buff_addr=0x10, acc_addr=0x4, calc_len=1, accepted at cycle 0 -> buff_rd_en_o with address 0x10 at cycle 1; mmu_sds_en_o at cycle 2; acc_wr_en_o with address 0x4 and accumulate_o=0 at cycle 18; busy_o high in cycle 1 only; resource_busy_o high in cycles 1..18.
- Burst with accumulate, signed and weights: opcode=0b111, calc_len=4, buff_addr=0x20, acc_addr=0x8 -> reads 0x20..0x23 in cycles 1..4; mmu_signed_o=1 in cycles 2..5; activate_weight_o high in cycle 2 only; writes 0x8..0xB with accumulate_o=1 in cycles 18..21.
- Back-to-back: calc_len=2, second instruction (opcode=0, acc_addr=0x30) asserted continuously -> accepted at cycle 3; reads at cycles 4..5; writes at cycles 18,19 with accumulate_o=1, then 21,22 with accumulate_o=0.
- Stall: calc_len=3, enable_i=0 in cycles 2..4 -> all outputs frozen during the stall; every later event shifted by 3; no duplicated or lost rows.
- Wrap and reset: buff_addr=max, calc_len=2 -> reads max then 0. Reset asserted at cycle 6 of a calc_len=8 run -> all outputs 0 immediately, and no acc_wr_en_o ever follows.
